mult_div_unit: RTL

//  Multicycle signed MULT/DIV unit driven by the control FSM; owns the HI/LO registers read by MFHI/MFLO.

---
 rtl/mult_div_unit_if.sv | 25 ++
 rtl/mult_div_unit.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/mult_div_unit_if.sv
// Handshake and result bus between the control FSM and the multiply/divide unit.
// The FSM drives the master side and the unit implements the slave side.
interface mult_div_unit_if #(
   parameter int WIDTH = 32
);
   logic             start_mult;
   logic             start_div;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             busy;
   logic             done;
   logic             div_zero;

   modport master (
      output start_mult, start_div, a, b,
      input  hi, lo, busy, done, div_zero
   );

   modport slave (
      input  start_mult, start_div, a, b,
      output hi, lo, busy, done, div_zero
   );
endinterface

// File: rtl/mult_div_unit.sv
// Multicycle signed MULT (radix-2 Booth) / DIV (restoring, on magnitudes) unit.
// It owns the HI/LO registers and flags divide-by-zero for the control FSM.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input logic           clock,
   input logic           reset,
   mult_div_unit_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [2:0] {IDLE, MULT, DIV, FIX, DONE} state_t;

   state_t           state, state_next;
   logic [CW-1:0]    count;
   // MULT: {partial product, multiplier, q(-1)}; DIV: {remainder, quotient/dividend, unused}
   logic [2*WIDTH:0] acc;
   logic [WIDTH-1:0] op;
   logic             is_div, neg_q, neg_r;
   logic [WIDTH-1:0] hi_q, lo_q;
   logic             busy_q, done_q, div_zero_q;

   logic             load_mult, load_div, last_iter;
   logic             busy_next, done_next, div_zero_next;

   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      state_next    = state;
      load_mult     = 1'b0;
      load_div      = 1'b0;
      div_zero_next = 1'b0;
      last_iter     = (count == CW'(WIDTH - 1));
      case (state)
         IDLE, DONE: begin
            state_next = IDLE;
            if (bus.start_mult) begin
               load_mult  = 1'b1;
               state_next = MULT;
            end else if (bus.start_div) begin
               if (bus.b != '0) begin
                  load_div   = 1'b1;
                  state_next = DIV;
               end else begin
                  div_zero_next = 1'b1;
               end
            end
         end
         MULT:    if (last_iter) state_next = FIX;
         DIV:     if (last_iter) state_next = FIX;
         FIX:     state_next = DONE;
         default: state_next = IDLE;
      endcase
      busy_next = (state_next == MULT) || (state_next == DIV) || (state_next == FIX);
      done_next = (state_next == DONE);
   end

   // The Booth add is done one bit wider so that subtracting the most negative
   // multiplicand cannot overflow before the arithmetic shift.
   logic [WIDTH:0]   upper_ext, m_ext, booth_sum;
   logic [2*WIDTH:0] mult_next;
   logic [WIDTH:0]   shifted, diff;
   logic             fits;
   logic [2*WIDTH:0] div_next;
   logic [WIDTH-1:0] a_mag, b_mag, rem_fixed, quo_fixed;

   always_comb begin
      upper_ext = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
      m_ext     = {op[WIDTH-1], op};
      case (acc[1:0])
         2'b01:   booth_sum = upper_ext + m_ext;
         2'b10:   booth_sum = upper_ext - m_ext;
         default: booth_sum = upper_ext;
      endcase
      mult_next = {booth_sum, acc[WIDTH:1]};

      shifted  = {acc[2*WIDTH:WIDTH+1], acc[WIDTH]};
      diff     = shifted - {1'b0, op};
      fits     = ~diff[WIDTH];
      div_next = {(fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0]), acc[WIDTH-1:1], fits, 1'b0};

      a_mag     = bus.a[WIDTH-1] ? -bus.a : bus.a;
      b_mag     = bus.b[WIDTH-1] ? -bus.b : bus.b;
      rem_fixed = neg_r ? -acc[2*WIDTH:WIDTH+1] : acc[2*WIDTH:WIDTH+1];
      quo_fixed = neg_q ? -acc[WIDTH:1] : acc[WIDTH:1];
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count      <= '0;
         acc        <= '0;
         op         <= '0;
         is_div     <= 1'b0;
         neg_q      <= 1'b0;
         neg_r      <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         busy_q     <= busy_next;
         done_q     <= done_next;
         div_zero_q <= div_zero_next;
         if (load_mult) begin
            count  <= '0;
            acc    <= {{WIDTH{1'b0}}, bus.b, 1'b0};
            op     <= bus.a;
            is_div <= 1'b0;
         end else if (load_div) begin
            count  <= '0;
            acc    <= {{WIDTH{1'b0}}, a_mag, 1'b0};
            op     <= b_mag;
            is_div <= 1'b1;
            neg_q  <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            neg_r  <= bus.a[WIDTH-1];
         end else begin
            case (state)
               MULT: begin
                  acc   <= mult_next;
                  count <= count + CW'(1);
               end
               DIV: begin
                  acc   <= div_next;
                  count <= count + CW'(1);
               end
               FIX: begin
                  hi_q <= is_div ? rem_fixed : acc[2*WIDTH:WIDTH+1];
                  lo_q <= is_div ? quo_fixed : acc[WIDTH:1];
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.hi       = hi_q;
   assign bus.lo       = lo_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.div_zero = div_zero_q;
endmodule
